// File: rtl/pack_tx_scheduler.sv
// Frames the packer's 128-bit words into header + fixed-length payload packets for the host link,
// buffering them in a small FIFO and counting words lost when the FIFO is full.
module pack_tx_scheduler #(
    parameter int          FIFO_DEPTH     = 16,
    parameter int          GROUPS_PER_PKT = 2,
    parameter logic [15:0] SYNC_WORD      = 16'hA55A
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         frequency_mode,
    input  logic [31:0]  select_dat_update,
    input  logic [127:0] packed_data,
    input  logic         packed_data_valid,
    output logic [127:0] tx_data,
    output logic         tx_valid,
    output logic         tx_last,
    input  logic         tx_ready,
    output logic [31:0]  frame_cnt,
    output logic [15:0]  drop_cnt,
    output logic         overflow
);

    localparam int          AW        = $clog2(FIFO_DEPTH);
    localparam int          CW        = AW + 1;
    localparam logic [15:0] PL_SINGLE = 16'(GROUPS_PER_PKT);
    localparam logic [15:0] PL_MULTI  = 16'(5 * GROUPS_PER_PKT);

    typedef enum logic [1:0] {IDLE, HDR, PAY} state_t;

    state_t         state_q, state_d;
    logic [127:0]   mem [FIFO_DEPTH];
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  count_q, count_d;
    logic [15:0]    pl_q, pl_d, cnt_q, cnt_d;
    logic [127:0]   data_q, data_d;
    logic           valid_q, valid_d, last_q, last_d;
    logic [31:0]    frame_q, frame_d;
    logic [15:0]    drop_q, drop_d;
    logic           ovf_q, ovf_d;
    logic           full, wr_en, rd_en;
    logic [15:0]    pl_now;

    assign full   = (count_q == CW'(FIFO_DEPTH));
    assign wr_en  = packed_data_valid && !full;
    assign pl_now = frequency_mode ? PL_MULTI : PL_SINGLE;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_q] <= packed_data;
        end
    end

    // The FIFO head is popped into the output register as the previous word is
    // accepted, so payload words follow each other without a bubble.
    always_comb begin
        state_d = state_q;
        pl_d    = pl_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        valid_d = valid_q;
        last_d  = last_q;
        frame_d = frame_q;
        drop_d  = drop_q;
        ovf_d   = ovf_q;
        rd_en   = 1'b0;

        if (packed_data_valid && full) begin
            ovf_d = 1'b1;
            if (drop_q != 16'hFFFF) begin
                drop_d = drop_q + 16'd1;
            end
        end

        case (state_q)
            IDLE: begin
                if (16'(count_q) >= pl_now) begin
                    state_d = HDR;
                    pl_d    = pl_now;
                    valid_d = 1'b1;
                    last_d  = 1'b0;
                    data_d  = {SYNC_WORD, 15'd0, frequency_mode, frame_q,
                               select_dat_update, 16'd0, pl_now};
                end
            end
            HDR: begin
                if (tx_ready) begin
                    rd_en   = 1'b1;
                    data_d  = mem[rd_ptr_q];
                    last_d  = (pl_q == 16'd1);
                    cnt_d   = 16'd0;
                    state_d = PAY;
                end
            end
            PAY: begin
                if (tx_ready) begin
                    if (last_q) begin
                        state_d = IDLE;
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                        data_d  = '0;
                        frame_d = frame_q + 32'd1;
                    end else begin
                        rd_en  = 1'b1;
                        data_d = mem[rd_ptr_q];
                        cnt_d  = cnt_q + 16'd1;
                        last_d = (cnt_q + 16'd2 == pl_q);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
                last_d  = 1'b0;
            end
        endcase

        wr_ptr_d = wr_ptr_q + AW'(wr_en);
        rd_ptr_d = rd_ptr_q + AW'(rd_en);
        count_d  = count_q + CW'(wr_en) - CW'(rd_en);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            pl_q     <= '0;
            cnt_q    <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            last_q   <= 1'b0;
            frame_q  <= '0;
            drop_q   <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            pl_q     <= pl_d;
            cnt_q    <= cnt_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            last_q   <= last_d;
            frame_q  <= frame_d;
            drop_q   <= drop_d;
            ovf_q    <= ovf_d;
        end
    end

    assign tx_data   = data_q;
    assign tx_valid  = valid_q;
    assign tx_last   = last_q;
    assign frame_cnt = frame_q;
    assign drop_cnt  = drop_q;
    assign overflow  = ovf_q;

endmodule

// File: doc/pack_tx_scheduler.md
Name: pack_tx_scheduler

Overview:
- Sits between the phase packer's 128-bit packed output (packed_data / packed_data_valid) and the host transmit link.
- Buffers packed words in an internal FIFO and frames them into packets: one header word followed by a fixed-length payload.
- Drives the link with a valid/ready handshake and last-word marker; flags and counts dropped words when the FIFO is full.

Parameters:
- FIFO_DEPTH, 16, 128-bit word entries in internal FIFO; power of two, >= 5*GROUPS_PER_PKT.
- GROUPS_PER_PKT, 2, packer output groups per packet (1 word/group in mode 0, 5 words/group in mode 1).
- SYNC_WORD, 16'hA55A, header marker in bits [127:112].

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- frequency_mode  in  1  0: single-frequency (1 word/group), 1: multi-frequency (5 words/group)
- select_dat_update  in  32  decimation setting, copied into header
- packed_data  in  128  packed word from packer
- packed_data_valid  in  1  packed word strobe; no backpressure to packer
- tx_data  out  128  link data
- tx_valid  out  1  link data valid
- tx_last  out  1  high on final payload word of packet
- tx_ready  in  1  link accepts word when tx_valid && tx_ready
- frame_cnt  out  32  packets fully sent
- drop_cnt  out  16  words dropped on FIFO full, saturates at 16'hFFFF
- overflow  out  1  sticky, set on first drop, cleared only by reset

Behaviour:
- Reset values: all outputs 0, FIFO empty, state IDLE.
- FIFO write:
  - On packed_data_valid with FIFO not full, write the word.
  - If full, drop the word, set overflow, and increment drop_cnt (saturating).
  - Write and read in the same cycle are allowed; a full FIFO with a simultaneous read still drops the incoming word (full is evaluated before the read).
- Payload length PL = frequency_mode ? 5*GROUPS_PER_PKT : GROUPS_PER_PKT. PL and frequency_mode are latched on the IDLE->HDR transition; mode changes mid-packet affect only the next packet.
- FSM:
  - IDLE: when FIFO count >= current PL, latch PL and mode, then go to HDR. Waiting for a full payload guarantees no underrun mid-packet.
  - HDR: present the header; on tx_ready go to PAY with payload counter = 0.
    - Header = {SYNC_WORD, 15'd0, mode_latched, frame_cnt, select_dat_update (sampled at HDR entry), 16'd0, PL[15:0]}.
  - PAY: present FIFO head. On each handshake, pop the FIFO and increment the counter. On the word where counter == PL-1, tx_last = 1; on its handshake go to IDLE and increment frame_cnt (wraps at 2^32).
- Output timing:
  - tx_valid is registered and stays high in HDR and PAY.
  - tx_data/tx_valid/tx_last must remain stable while tx_valid && !tx_ready.
  - Back-to-back packets are allowed: IDLE->HDR may occur the cycle after the last handshake.
  - Minimum latency from the PL-th FIFO write to header tx_valid = 2 clocks.
- Throughput: one word per clock when tx_ready is held high. The FWFT FIFO read path is registered, so the PAY-state data must not bubble.
- Reset mid-packet: immediate abort, FIFO flushed, counters cleared; no partial tx_last is issued.
- The packer never bursts more than 5 words, so FIFO_DEPTH >= 5*GROUPS_PER_PKT + 5 avoids drops at full link rate. Drops occur only under sustained tx_ready low.

Test Plan:
- Mode 0, GROUPS_PER_PKT=2, tx_ready=1, two single words W0,W1 -> header (PL=2, frame_cnt=0, mode=0) then W0, W1 with tx_last on W1; frame_cnt=1.
- Mode 1, one 5-word burst then a second 5-word burst 20 clocks later -> header PL=10, then the 10 words in order, tx_last on the 10th, no bubbles once the header is accepted.
- tx_ready toggled 1/0 every clock during PAY -> words stable while stalled, sequence unchanged, exactly one tx_last.
- tx_ready=0, FIFO_DEPTH=16, 18 words written -> FIFO holds the first 16, drop_cnt=2, overflow=1; after release, packets carry the first 16 words only.
- frequency_mode switched 0->1 after the header of packet 0 -> packet 0 keeps PL=2 and mode=0; packet 1 header shows PL=10 and mode=1.
- rst_n asserted while in PAY at word 3 of 10 -> all outputs 0 the same cycle (async); after release no tx_valid until PL new words arrive.
